// File: rtl/haski_result_stream.sv
// Buffered result-output stage: queues reducer result words in a circular FIFO,
// drains them over valid/ready, and reports halt only after the queue is empty.
module haski_result_stream #(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 8,
    parameter bit BACKPRESSURE = 1'b1
) (
    input  logic                    system1000,
    input  logic                    system1000_rst,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_halt,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    input  logic                    out_ready,
    output logic                    out_halted,
    output logic                    overflow,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               push;
    logic               pop;
    logic               drop;

    // Ready depends only on registered state, never on out_ready.
    assign in_ready   = (level < FULL_LVL) && (state == RUN);
    assign out_valid  = (level != '0);
    assign out_data   = mem[rd_ptr];
    assign out_halted = (state == HALTED);
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign drop       = !BACKPRESSURE && (state == RUN) && in_valid && (level == FULL_LVL);

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:    if (in_halt) state_nxt = DRAIN;
            // Leave DRAIN on the edge where the queue becomes (or already is) empty.
            DRAIN:  if ((level == '0) || ((level == LVL_W'(1)) && pop)) state_nxt = HALTED;
            HALTED: state_nxt = HALTED;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            state    <= RUN;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            if (drop)
                overflow <= 1'b1;
        end
    end

    // Storage is data, not control: left unreset.
    always_ff @(posedge system1000) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

endmodule

// File: doc/haski_result_stream.md
# haski_result_stream

Parametrised result-output stage for the HaSKI reduction machine top level. It replaces the single registered `{valid, word, halted}` output triple with a buffered stream. Result words from the reducer core are queued in a DEPTH-entry FIFO and drained through a valid/ready port. The halt indication is deferred until every queued word has been delivered. The block sits between the reducer core and the top-entity output pins.

## Interface
- `DATA_W`, 32: width of a result word.
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `BACKPRESSURE`, 1: selects full-FIFO behaviour.
  - 1: the core stalls on `in_ready`.
  - 0: the core never stalls; words offered while full are dropped and set `overflow`.

Ports:
- `system1000`, in, 1: clock; all state changes on the rising edge.
- `system1000_rst`, in, 1: reset, asynchronous, active-high.
- `in_valid`, in, 1: core offers `in_data` this cycle.
- `in_data`, in, DATA_W: result word from the core.
- `in_halt`, in, 1: single-cycle pulse; the core has reached normal form.
- `in_ready`, out, 1: the FIFO accepts a word this cycle.
- `out_valid`, out, 1: `out_data` holds the oldest queued word.
- `out_data`, out, DATA_W: head of the FIFO.
- `out_ready`, in, 1: consumer accepts `out_data`.
- `out_halted`, out, 1: sticky; the core halted and all its words have been delivered.
- `overflow`, out, 1: sticky; at least one word was dropped (`BACKPRESSURE`=0 only).
- `level`, out, clog2(DEPTH)+1: current occupancy, 0..DEPTH.

## Operation
- **Storage:** circular buffer, `DEPTH` entries, with a write pointer and a read pointer of clog2(DEPTH) bits each. Pointers wrap modulo `DEPTH`. A separate occupancy counter drives `level`.
- **Push:** occurs when `in_valid && in_ready`. `in_data` is written at the write pointer, then the write pointer increments.
- **Pop:** occurs when `out_valid && out_ready`. The read pointer increments.
- **Occupancy:**
  - `level` updates by +push −pop.
  - Simultaneous push and pop leave `level` unchanged.
  - Push and pop are both legal when 0 < `level` < `DEPTH`.
- **Ready and valid:**
  - `in_ready` = (`level` < `DEPTH`) && state==RUN.
  - `in_ready` is never a function of `out_ready`, so a full FIFO refuses a push even when a pop happens in the same cycle.
  - `out_valid` = (`level` != 0).
  - `out_data` = mem[rd_ptr], valid whenever `out_valid`=1.
- **Overflow:** with `BACKPRESSURE`=0, `in_valid` in RUN with `level`==`DEPTH` drops the word and sets `overflow`. With `BACKPRESSURE`=1, `overflow` stays 0.
- **State machine:** RUN, DRAIN, HALTED.
  - RUN → DRAIN on `in_halt`. If `in_valid` is also high in that cycle, the word is pushed normally when `in_ready`=1, otherwise it is handled as a normal full-FIFO refusal.
  - DRAIN: `in_ready`=0 and `in_valid` is ignored. It does not set `overflow`. Pops continue.
  - DRAIN → HALTED on the cycle in which `level` is 0. This includes the cycle the last word pops: `level` reads 0 on the following cycle, and HALTED is entered on that same edge.
  - HALTED: `out_halted`=1 and `in_ready`=0. The state is terminal until reset.
  - `in_halt` in DRAIN or HALTED has no effect.
- **Reset:** asserting `system1000_rst` at any time clears pointers, `level`, `overflow` and the state (→RUN), discarding queued words. Memory contents are not reset.

## Timing
- **Reset values:**
  - `in_ready`=1.
  - `out_valid`=0, `out_halted`=0, `overflow`=0, `level`=0.
  - `out_data`: don't-care.
- **Latency:**
  - A word pushed on edge N is visible on `out_data` with `out_valid`=1 after edge N (one cycle).
  - Fall-through of an empty FIFO is not combinational.
- **Throughput:** one push and one pop per cycle sustained.
- **Halt:**
  - With the FIFO empty when `in_halt` is sampled on edge N: DRAIN after N, HALTED after N+1.
  - With k words queued and `out_ready` held high: `out_halted` rises one cycle after the last pop.
- **Stability:** `out_data` and `out_valid` hold while `out_valid && !out_ready`.

## Test plan
1. **Reset:** reset asserted mid-stream with `level`=5 → `level`=0, `out_valid`=0, `in_ready`=1 immediately (asynchronous, before the next clock edge). Reset released → pushes resume from empty.
2. **Stream order:** push 0x1..0x8 back-to-back with `out_ready`=0, `DEPTH`=8 → `level`=8, `in_ready`=0. Then `out_ready`=1 → 0x1..0x8 appear in order, one per cycle.
3. **Wrap and full:** simultaneous push/pop at full (`level`=8) → push refused, `level`=7. Then push 0xA5 with a simultaneous pop → `level` stays 7. Continue for 20 cycles → pointers wrap and the order is preserved.
4. **Halt drain:** 3 words queued, `in_halt` pulse, `out_ready` stalled 4 cycles then high → `in_ready`=0 from the cycle after the pulse. The 3 words are delivered. `out_halted`=1 one cycle after the third pop, and stays 1.
5. **Overflow:** `BACKPRESSURE`=0, FIFO full, `in_valid` with 0xDEAD → word dropped, `overflow`=1 sticky, existing contents intact. With `BACKPRESSURE`=1, the same stimulus → `overflow`=0.
6. **Halt with word:** `in_halt` and `in_valid` (0x42) in the same cycle on an empty FIFO → 0x42 delivered, then `out_halted`=1. A later `in_valid` is ignored.
